// File: rtl/valu_seq.sv
// valu_seq: element-serial vector ALU for add / mul / dot micro-ops at fixed SEW
// or variable precision (vap), plus a sum reduction. One element is processed
// per cycle from right-shifting operand copies latched at accept.
module valu_seq #(
    parameter int VLEN = 128,
    parameter int ELEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      micro_exec_instr,
    input  logic [9:0]      SEW,
    input  logic [3:0]      vap,
    input  logic [VLEN-1:0] opA,
    input  logic [VLEN-1:0] opB,
    input  logic [VLEN-1:0] opC,
    output logic [VLEN-1:0] alu_out,
    output logic            alu_done,
    output logic            alu_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DOT  = 3'd2;
    localparam logic [2:0] OP_ADDV = 3'd3;
    localparam logic [2:0] OP_MULV = 3'd4;
    localparam logic [2:0] OP_DOTV = 3'd5;
    localparam logic [2:0] OP_RED  = 3'd6;

    // Bit-position width: must hold pos + 2*ew for the end-of-vector test.
    localparam int PW = $clog2(VLEN) + 2;

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [6:0]      ew_q, ew_d;
    logic [VLEN-1:0] a_q, a_d;
    logic [VLEN-1:0] b_q, b_d;
    logic [VLEN-1:0] c_q, c_d;
    logic [VLEN-1:0] out_q, out_d;
    logic            err_q, err_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [63:0]     acc_q, acc_d;

    logic            req_legal;
    logic [6:0]      req_ew;
    logic [63:0]     ew_mask;
    logic [63:0]     a_el, b_el, c_el;
    logic [63:0]     prod, elem_raw, elem_res, acc_sum;
    logic [PW-1:0]   pos_nxt;
    logic            last;

    assign in_ready = (state_q == S_IDLE);
    assign alu_done = (state_q == S_DONE);
    assign alu_out  = out_q;
    assign alu_err  = err_q;

    // Decode the requested element width and whether the request is legal.
    always_comb begin
        req_legal = 1'b0;
        req_ew    = '0;
        case (micro_exec_instr)
            8'h00, 8'h01, 8'h02, 8'h06: begin
                req_ew    = SEW[6:0];
                req_legal = (SEW == 10'd8) || (SEW == 10'd16) || (SEW == 10'd32) ||
                            ((SEW == 10'd64) && (ELEN >= 64));
            end
            8'h03, 8'h04, 8'h05: begin
                req_ew    = {3'b000, vap};
                req_legal = (vap != 4'd0) && (vap <= 4'd8);
            end
            default: begin
                req_ew    = '0;
                req_legal = 1'b0;
            end
        endcase
    end

    // Per-element datapath on the low ew bits of the shifting operands.
    always_comb begin
        ew_mask  = (ew_q == 7'd64) ? '1 : ((64'd1 << ew_q) - 64'd1);
        a_el     = a_q[63:0] & ew_mask;
        b_el     = b_q[63:0] & ew_mask;
        c_el     = c_q[63:0] & ew_mask;
        prod     = a_el * b_el;
        // Reduction seeds the accumulator with C element 0 on the first step.
        acc_sum  = ((idx_q == '0) ? c_el : acc_q) + prod;
        case (op_q)
            OP_ADD, OP_ADDV: elem_raw = a_el + b_el;
            OP_MUL, OP_MULV: elem_raw = prod;
            OP_DOT, OP_DOTV: elem_raw = prod + c_el;
            default:         elem_raw = prod + c_el;
        endcase
        elem_res = elem_raw & ew_mask;
        pos_nxt  = pos_q + PW'(ew_q);
        last     = (pos_nxt + PW'(ew_q)) > PW'(VLEN);
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ew_d    = ew_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        out_d   = out_q;
        err_d   = err_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = micro_exec_instr[2:0];
                    ew_d    = req_ew;
                    a_d     = opA;
                    b_d     = opB;
                    c_d     = opC;
                    out_d   = '0;
                    err_d   = ~req_legal;
                    idx_d   = '0;
                    pos_d   = '0;
                    acc_d   = '0;
                    state_d = req_legal ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (op_q == OP_RED) begin
                    acc_d = acc_sum;
                    if (last) begin
                        out_d = VLEN'(acc_sum & ew_mask);
                    end
                end else begin
                    out_d = out_q | (VLEN'(elem_res) << pos_q);
                end
                a_d   = a_q >> ew_q;
                b_d   = b_q >> ew_q;
                c_d   = c_q >> ew_q;
                idx_d = idx_q + 1'b1;
                pos_d = pos_nxt;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ew_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            pos_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ew_q    <= ew_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            out_q   <= out_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_valu_seq.sv
// Directed testbench for valu_seq at VLEN=128, ELEN=64.
module tb_valu_seq;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   micro_exec_instr;
    logic [9:0]   SEW;
    logic [3:0]   vap;
    logic [127:0] opA, opB, opC;
    logic [127:0] alu_out;
    logic         alu_done;
    logic         alu_err;

    int n_checks;
    int n_errors;

    valu_seq #(.VLEN(128), .ELEN(64)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .micro_exec_instr (micro_exec_instr),
        .SEW              (SEW),
        .vap              (vap),
        .opA              (opA),
        .opB              (opB),
        .opC              (opC),
        .alu_out          (alu_out),
        .alu_done         (alu_done),
        .alu_err          (alu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for done, check latency, result, error flag,
    // busy behaviour and the single-cycle done pulse. With hold set, in_valid
    // stays high and the operand inputs are scrambled after accept.
    task automatic run_req(input string tag, input logic [7:0] op, input logic [9:0] sew,
                           input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] c, input logic [127:0] exp_out,
                           input logic exp_err, input int exp_edge, input bit hold);
        int waitc;
        int lat;
        int busy_bad;
        @(negedge clk);
        micro_exec_instr = op;
        SEW = sew;
        vap = v;
        opA = a;
        opB = b;
        opC = c;
        in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " ready"}, 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            opA = {$urandom, $urandom, $urandom, $urandom};
            opB = {$urandom, $urandom, $urandom, $urandom};
            opC = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        busy_bad = 0;
        while (!alu_done && lat < 300) begin
            if (in_ready) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) busy_bad++;
        check({tag, " done edge"}, 128'(lat + 1), 128'(exp_edge));
        check({tag, " busy"}, 128'(busy_bad), 128'd0);
        check({tag, " out"}, alu_out, exp_out);
        check({tag, " err"}, 128'(alu_err), 128'(exp_err));
        @(posedge clk);
        #1;
        check({tag, " pulse"}, 128'(alu_done), 128'd0);
        check({tag, " idle"}, 128'(in_ready), 128'd1);
        check({tag, " hold"}, alu_out, exp_out);
    endtask

    logic [127:0] exp3;
    int pulses;

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        in_valid = 1'b0;
        micro_exec_instr = '0;
        SEW = '0;
        vap = '0;
        opA = '0;
        opB = '0;
        opC = '0;

        #12;
        check("rst ready", 128'(in_ready), 128'd1);
        check("rst done", 128'(alu_done), 128'd0);
        check("rst err", 128'(alu_err), 128'd0);
        check("rst out", alu_out, 128'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_req("vdot32", 8'h02, 10'd32, 4'd0,
                128'h0000312100001e430000aa2300001111, 128'h0000312100001e430000aa2300001111,
                128'h22221111222211112222111122221111,
                128'h2b8fb75225b5d69a933491da23455432, 1'b0, 5, 1'b0);
        run_req("vmul32", 8'h01, 10'd32, 4'd0,
                128'h0000312100001e430000aa2300001111, 128'h0000312100001e430000aa2300001111,
                128'h0, 128'h096da6410393c589711280c901234321, 1'b0, 5, 1'b0);
        run_req("vaddv8", 8'h03, 10'd0, 4'd8,
                128'h0807060504030201, 128'h0807060504030201, 128'h0,
                128'h100e0c0a08060402, 1'b0, 17, 1'b0);
        run_req("vred16", 8'h06, 10'd16, 4'd0,
                {8{16'h0002}}, {8{16'h0002}}, 128'h5, 128'h25, 1'b0, 9, 1'b0);

        exp3 = '0;
        for (int i = 0; i < 42; i++) exp3[i*3 +: 3] = 3'b110;
        run_req("vaddv3", 8'h03, 10'd0, 4'd3, '1, '1, 128'h0, exp3, 1'b0, 43, 1'b0);
        run_req("vmulv1", 8'h04, 10'd0, 4'd1, '1, {8{16'hAAAA}}, 128'h0,
                {8{16'hAAAA}}, 1'b0, 129, 1'b0);
        run_req("vdotv4", 8'h05, 10'd0, 4'd4, {32{4'h3}}, {32{4'h3}}, {32{4'h1}},
                {32{4'hA}}, 1'b0, 33, 1'b0);

        // Back-to-back with in_valid held high across requests.
        run_req("vmul64", 8'h01, 10'd64, 4'd0,
                {64'h2, 64'hFFFFFFFFFFFFFFFF}, {64'h3, 64'h2}, 128'h0,
                {64'h6, 64'hFFFFFFFFFFFFFFFE}, 1'b0, 3, 1'b1);
        run_req("ill sew24", 8'h00, 10'd24, 4'd0, '1, '1, '1, 128'h0, 1'b1, 1, 1'b1);
        run_req("ill vap0", 8'h03, 10'd0, 4'd0, '1, '1, '1, 128'h0, 1'b1, 1, 1'b1);
        run_req("ill op07", 8'h07, 10'd8, 4'd4, '1, '1, '1, 128'h0, 1'b1, 1, 1'b0);

        // Reset two cycles into a SEW=8 add.
        @(negedge clk);
        micro_exec_instr = 8'h00;
        SEW = 10'd8;
        opA = {16{8'h81}};
        opB = {16{8'h80}};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("abort out", alu_out, 128'd0);
        check("abort ready", 128'(in_ready), 128'd1);
        check("abort done", 128'(alu_done), 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (alu_done) pulses++;
        end
        check("abort no done", 128'(pulses), 128'd0);

        run_req("vadd8", 8'h00, 10'd8, 4'd0, {16{8'h81}}, {16{8'h80}}, 128'h0,
                {16{8'h01}}, 1'b0, 17, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/valu_seq.md
# valu_seq

Parametrised, element-serial vector ALU that executes the vector arithmetic micro-ops (add, multiply, multiply-accumulate) over a configurable register width VLEN. It supports the fixed-SEW variants, the variable-precision (vap) variants, and a new reduction op. It sits in the vector execute stage behind the micro-op decoder. Operands are accepted through a valid/ready handshake, one element is processed per cycle, and completion is signalled with a single-cycle done pulse. The bit-exact results of the current 128-bit ALU are preserved at VLEN=128.

## Interface
- VLEN, 128: vector register width in bits; multiple of 64, at least 64.
- ELEN, 64: maximum SEW in bits; one of 32 or 64.

- clk  input  1  clock.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block idle and able to accept.
- micro_exec_instr  input  8  opcode: 00 vadd.vv, 01 vmul.vv, 02 vdot.vv, 03 vaddvarp, 04 vmulvarp, 05 vdotvarp, 06 vredsum.
- SEW  input  10  element width in bits for ops 00/01/02/06; legal values 8, 16, 32, 64 (must be ≤ELEN).
- vap  input  4  element width in bits for ops 03/04/05; legal values 1..8.
- opA, opB, opC  input  VLEN  source vectors; elements are packed contiguously from bit 0.
- alu_out  output  VLEN  result vector.
- alu_done  output  1  one-cycle completion pulse.
- alu_err  output  1  illegal op or width for the last accepted request; held until the next accept.

## Operation
- Element width: ew = SEW for ops 00/01/02/06, and ew = vap for ops 03/04/05. Element count N = floor(VLEN/ew).
- Result bits at and above N·ew are always 0 (e.g. vap=3 at VLEN=128 gives N=42 and bits 127:126 = 0).
- Per-element arithmetic is modulo 2^ew, with no saturation and no sign distinction:
  - add: A+B
  - mul: low ew bits of A·B
  - dot (02, 05): A·B + C
- vredsum: element 0 of the result = C[0] + Σ A[i]·B[i] mod 2^ew; all other elements are 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, latch opcode, ew and operands, clear alu_out and alu_err, and set idx=0.
  - On accept with a legal request: go to RUN.
  - On accept with an illegal request (unknown opcode, illegal SEW or SEW>ELEN, vap=0 or vap>8): set alu_err=1, keep alu_out=0, go to DONE.
  - RUN: each cycle, compute element idx from the low ew bits of operand shift registers, write it to alu_out[idx·ew +: ew] (vredsum updates an accumulator instead), shift the operands right by ew, and increment idx. After element N-1, go to DONE; vredsum writes the accumulator to element 0 at this point.
  - DONE: alu_done=1, in_ready=0; next state is IDLE.
- alu_out is held stable from DONE until the next accept.
- in_valid is ignored while in_ready=0; the operands of an ignored request are not sampled.
- Opcode, width and operands are latched at accept. Input changes after accept have no effect.

## Timing
- Reset, asynchronous and any time: state=IDLE, in_ready=1, alu_out=0, alu_done=0, alu_err=0, idx=0, accumulator=0.
- A reset during RUN aborts the operation: no alu_done, partial results are discarded, and alu_out reads 0.
- Accept happens at the rising edge E0 where in_valid && in_ready.
- Legal request: RUN occupies N cycles. alu_done is high for exactly the cycle between edges E0+N and E0+N+1, so it is sampled high at E0+N+1. alu_out is final when alu_done is high.
- Illegal request: alu_done is sampled high at E0+1.
- Back-to-back: in_ready returns high the cycle after alu_done, so the next accept is earliest at E0+N+2.
- alu_done is never high for two consecutive cycles.

## Test plan
- vdot (02), SEW=32, opA=opB=0000312100001e430000aa2300001111, opC=22221111222211112222111122221111 -> alu_out=2b8fb75225b5d69a933491da23455432, alu_err=0, alu_done sampled at E0+5.
- vmul (01), SEW=32, same opA/opB -> 096da6410393c589711280c901234321. Also vaddvarp (03), vap=8, opA=opB=0x0807060504030201 -> 0x100e0c0a08060402, done at E0+17.
- vredsum (06), SEW=16, opA=opB=all elements 0x0002, opC=0x0005 in element 0 -> alu_out=0x0025 (higher bits 0), done at E0+9.
- vaddvarp, vap=3, opA=opB=all ones -> 42 elements each 3'b110, bits 127:126 = 0. vap=1 vmulvarp with opA=all ones and opB=0xAAAA… -> 0xAAAA….
- Illegal requests (SEW=24, vap=0, opcode 07) -> alu_err=1, alu_out=0, alu_done at E0+1. in_valid held high across the following requests: the second accept occurs only after done, and in_ready=0 throughout RUN/DONE.
- Drop resetn two cycles into a SEW=8 vadd -> alu_out=0, alu_done never pulses, in_ready=1 immediately. After release, a new vadd completes normally with correct results.
